inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Front-end stage directly upstream of the decoder. Issues sequential fetch requests to the instruction cache and buffers the returned words in a small instruction queue.
- Statically predicts control flow (JAL and backward branches taken) and presents one {inst, pc, pd} per cycle to the decoder.
- Accepts a redirect/flush from the ROB on misprediction.

Parameters:
- RESET_PC, 32'h0, PC of first fetch after reset.
- QDEPTH_LOG, 3, log2 of instruction queue depth (depth 8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- rdy  in  1  global ready; when 0, all state frozen.
- oIC_en  out  1  fetch request valid; held until iIC_valid.
- oIC_pc  out  32  fetch address; stable while oIC_en=1.
- iIC_valid  in  1  fetch data valid, one-cycle pulse.
- iIC_inst  in  32  fetched instruction word.
- iDEC_stall  in  1  downstream (ROB/RS full) cannot accept this cycle.
- oDEC_en  out  1  instruction valid to decoder, one cycle per instruction.
- oDEC_inst  out  32  instruction.
- oDEC_pc  out  32  instruction PC.
- oDEC_pd  out  1  predicted taken (1=Jump, 0=NotJump).
- iROB_flush  in  1  mispredict redirect.
- iROB_pc  in  32  redirect target.

Behaviour:
- Reset (rst=0 at posedge):
  - oIC_en=0, oIC_pc=0, oDEC_en=0, oDEC_inst=0, oDEC_pc=0, oDEC_pd=0.
  - Queue empty, count=0, head=tail=0, fetch pc=RESET_PC, state=IDLE.
  - Reset overrides rdy and flush; reset during an outstanding fetch abandons it with no DROP state.
- rdy=0: no register changes; flush and iIC_valid are not sampled. Upstream holds these signals.
- Fetch FSM, states IDLE, WAIT, DROP:
  - IDLE: if count < 2^QDEPTH_LOG, register oIC_en=1 and oIC_pc=pc, then go to WAIT. Otherwise stay with oIC_en=0.
  - WAIT: oIC_en stays 1.
    - On iIC_valid: enqueue {iIC_inst, oIC_pc, pd}, set pc=next_pc, oIC_en=0, go to IDLE.
  - DROP: oIC_en=0. On iIC_valid, discard the data and go to IDLE.
  - Back-to-back requests are separated by at least one IDLE cycle.
  - The outstanding request counts as a reserved slot, so an enqueue never overflows.
- Prediction (computed from iIC_inst at enqueue):
  - opcode 1101111 (JAL): pd=1, next_pc = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - opcode 1100011 (branch) with inst[31]=1 (backward): pd=1, next_pc = pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - All others, including JALR and forward branches: pd=0, next_pc = pc+4.
  - All address arithmetic is 32-bit and wraps modulo 2^32.
- Issue:
  - Each posedge with count>0 and iDEC_stall=0: oDEC_en=1 with the head entry, head++, count--.
  - Otherwise oDEC_en=0; the other oDEC_* outputs hold their last value.
  - Latency: iIC_valid at cycle N gives oDEC_en=1 at cycle N+2 when the queue was empty and there is no stall.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Pointers wrap modulo 2^QDEPTH_LOG.
- Flush (iROB_flush=1, rdy=1): highest priority after reset.
  - Queue cleared (count=0, head=tail), oDEC_en=0, pc=iROB_pc, oIC_en=0.
  - Next state depends on the current state:
    - WAIT without iIC_valid this cycle: go to DROP.
    - WAIT with iIC_valid this cycle: data discarded, go to IDLE.
    - IDLE or DROP: state unchanged.
  - The first fetch after a flush addresses iROB_pc at the earliest one cycle later. No instruction fetched before the flush ever reaches oDEC_en after it.
- Full queue: no new request. Requests resume in the cycle after a dequeue frees a slot.

Test Plan:
- Reset with RESET_PC=0x0, then icache returns 0x00000013 (addi nop) every request → oIC_pc sequence 0x0,0x4,0x8. oDEC_en first high 2 cycles after the first iIC_valid, with pd=0 and pc=0x0.
- Hold iDEC_stall=1 for 40 cycles → exactly 8 entries enqueued and oIC_en stays 0 afterward. Release stall → 8 consecutive oDEC_en pulses with PCs in order, then fetching resumes.
- JAL 0x0080006F at pc 0x10 → oDEC_pd=1 and the next oIC_pc=0x18. Forward BEQ 0x00000463 → pd=0 and next 0x20. Backward BEQ 0xFE000EE3 at 0x20 → pd=1 and next 0x1C.
- iROB_flush with iROB_pc=0x100 while in WAIT; iIC_valid arrives 3 cycles later → that word is dropped and the queue is empty. The next oIC_pc=0x100, and no pre-flush PC appears on oDEC_pc.
- Flush in the same cycle as iIC_valid and a dequeue → no oDEC_en next cycle, count=0, state IDLE, then a fetch at iROB_pc.
- rdy=0 for 5 cycles mid-WAIT with iIC_valid pulsed → no state or output change. After rdy=1, operation continues from the frozen state; a rdy=0 cycle combined with flush has no effect.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential icache requests, static branch prediction,
// an 8-entry instruction queue feeding the decoder, and ROB redirect handling.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          QDEPTH_LOG = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        oIC_en,
  output logic [31:0] oIC_pc,
  input  logic        iIC_valid,
  input  logic [31:0] iIC_inst,
  input  logic        iDEC_stall,
  output logic        oDEC_en,
  output logic [31:0] oDEC_inst,
  output logic [31:0] oDEC_pc,
  output logic        oDEC_pd,
  input  logic        iROB_flush,
  input  logic [31:0] iROB_pc
);

  localparam int DEPTH = 1 << QDEPTH_LOG;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [QDEPTH_LOG:0]   CNT_ZERO_C = {(QDEPTH_LOG+1){1'b0}};
  localparam logic [QDEPTH_LOG:0]   CNT_ONE_C  = {{QDEPTH_LOG{1'b0}}, 1'b1};
  localparam logic [QDEPTH_LOG:0]   CNT_FULL_C = {1'b1, {QDEPTH_LOG{1'b0}}};
  localparam logic [QDEPTH_LOG-1:0] PTR_ZERO_C = {QDEPTH_LOG{1'b0}};
  localparam logic [QDEPTH_LOG-1:0] PTR_ONE_C  = {{(QDEPTH_LOG-1){1'b0}}, 1'b1};

  // Static prediction: returns {taken, next_pc} for a word fetched at pc.
  function automatic logic [32:0] predict(input logic [31:0] inst, input logic [31:0] pc);
    logic [31:0] imm_jal;
    logic [31:0] imm_br;
    logic [32:0] res;
    imm_jal = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_br  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    case (inst[6:0])
      7'b1101111: res = {1'b1, pc + imm_jal};
      7'b1100011: begin
        if (inst[31]) begin
          res = {1'b1, pc + imm_br};
        end else begin
          res = {1'b0, pc + 32'd4};
        end
      end
      default:    res = {1'b0, pc + 32'd4};
    endcase
    return res;
  endfunction

  logic [1:0]            state_r;
  logic [31:0]           pc_r;
  logic [QDEPTH_LOG-1:0] head_r;
  logic [QDEPTH_LOG-1:0] tail_r;
  logic [QDEPTH_LOG:0]   count_r;
  logic [31:0]           q_inst_r [DEPTH];
  logic [31:0]           q_pc_r   [DEPTH];
  logic                  q_pd_r   [DEPTH];

  logic                  enq_s;
  logic                  deq_s;
  logic                  pred_pd_s;
  logic [31:0]           pred_npc_s;
  logic [QDEPTH_LOG:0]   count_nx_s;

  // Enqueue/dequeue decisions, prediction of the returning word and next occupancy.
  always_comb begin
    enq_s                   = (state_r == ST_WAIT) && iIC_valid;
    deq_s                   = (count_r != CNT_ZERO_C) && !iDEC_stall;
    {pred_pd_s, pred_npc_s} = predict(iIC_inst, oIC_pc);
    if (enq_s && !deq_s) begin
      count_nx_s = count_r + CNT_ONE_C;
    end else if (!enq_s && deq_s) begin
      count_nx_s = count_r - CNT_ONE_C;
    end else begin
      count_nx_s = count_r;
    end
  end

  // Fetch FSM, instruction queue and decoder issue; a flush wipes the queue and
  // turns an in-flight request into one whose data is thrown away on return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC;
      head_r    <= PTR_ZERO_C;
      tail_r    <= PTR_ZERO_C;
      count_r   <= CNT_ZERO_C;
      oIC_en    <= 1'b0;
      oIC_pc    <= 32'h0000_0000;
      oDEC_en   <= 1'b0;
      oDEC_inst <= 32'h0000_0000;
      oDEC_pc   <= 32'h0000_0000;
      oDEC_pd   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst_r[i] <= 32'h0000_0000;
        q_pc_r[i]   <= 32'h0000_0000;
        q_pd_r[i]   <= 1'b0;
      end
    end else if (rdy) begin
      if (iROB_flush) begin
        head_r  <= tail_r;
        count_r <= CNT_ZERO_C;
        oDEC_en <= 1'b0;
        oIC_en  <= 1'b0;
        pc_r    <= iROB_pc;
        case (state_r)
          ST_WAIT: state_r <= iIC_valid ? ST_IDLE : ST_DROP;
          ST_IDLE: state_r <= ST_IDLE;
          ST_DROP: state_r <= ST_DROP;
          default: state_r <= ST_IDLE;
        endcase
      end else begin
        if (deq_s) begin
          oDEC_en   <= 1'b1;
          oDEC_inst <= q_inst_r[head_r];
          oDEC_pc   <= q_pc_r[head_r];
          oDEC_pd   <= q_pd_r[head_r];
          head_r    <= head_r + PTR_ONE_C;
        end else begin
          oDEC_en   <= 1'b0;
        end
        if (enq_s) begin
          q_inst_r[tail_r] <= iIC_inst;
          q_pc_r[tail_r]   <= oIC_pc;
          q_pd_r[tail_r]   <= pred_pd_s;
          tail_r           <= tail_r + PTR_ONE_C;
        end
        count_r <= count_nx_s;
        // The in-flight request reserves its slot, so only issue below full.
        case (state_r)
          ST_IDLE: begin
            if (count_r < CNT_FULL_C) begin
              oIC_en  <= 1'b1;
              oIC_pc  <= pc_r;
              state_r <= ST_WAIT;
            end else begin
              oIC_en  <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (iIC_valid) begin
              pc_r    <= pred_npc_s;
              oIC_en  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              oIC_en  <= 1'b1;
            end
          end
          ST_DROP: begin
            oIC_en <= 1'b0;
            if (iIC_valid) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DROP;
            end
          end
          default: begin
            oIC_en  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
